layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Sequences one fully-connected layer through a single PreActivation datapath instance.
//  Accepts an input vector x, then for neuron j = 0..M-1:
//    - fetches weight row j and bias j from an external weight memory,
//    - computes the pre-activation,
//    - streams the result out with a valid/ready handshake.
//  Sits between the input buffer and the activation stage; owns the weight-memory read port.
// PARAMETERS
//  N          `N                         vector length (elements per x / weight row)
//  DATA_WIDTH `DATA_WIDTH                signed element / bias width
//  M          8                          neurons per layer (rows in weight memory), M >= 1
//  ACC_WIDTH  DATA_WIDTH*2+$clog2(N)     signed pre-activation width
//  IDX_WIDTH  (M>1)?$clog2(M):1          neuron index / weight address width
// PORTS
//  clk       in   1                clock, all state on rising edge
//  rst_n     in   1                reset, asynchronous, active-low
//  abort     in   1                synchronous abandon of current layer
//  in_valid  in   1                input vector x offered
//  in_ready  out  1                sequencer can accept x
//  in_x      in   N*DATA_WIDTH     packed signed x, element i at [i*DATA_WIDTH+:DATA_WIDTH]
//  w_req     out  1                weight-memory read strobe
//  w_addr    out  IDX_WIDTH        row address (= neuron index)
//  w_rdata   in   N*DATA_WIDTH     packed weight row, valid exactly 1 cycle after w_req
//  b_rdata   in   DATA_WIDTH       bias for that row, same timing as w_rdata
//  out_valid out  1                out_pre/out_idx/out_last valid
//  out_ready in   1                downstream accepts result
//  out_pre   out  ACC_WIDTH        signed dot(x,w_j) + sign-extended b_j
//  out_idx   out  IDX_WIDTH        neuron index j of out_pre
//  out_last  out  1                out_idx == M-1
//  busy      out  1                state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async):
//    - state=IDLE, idx=0, x_reg=0.
//    - Registered outputs (out_pre, out_idx, out_last, out_valid, w_req, w_addr) = 0.
//    - in_ready=1 and busy=0, since both decode from state=IDLE.
//  FSM (one-hot or enum), all decoded outputs derive from state:
//    IDLE:
//      - in_ready=1.
//      - in_valid & in_ready: latch in_x into x_reg, idx<=0, go FETCH.
//    FETCH (1 cycle):
//      - w_req=1, w_addr=idx; go CAPTURE.
//    CAPTURE (1 cycle):
//      - w_rdata/b_rdata valid.
//      - out_pre<=PreActivation(x_reg,w_rdata,b_rdata); out_idx<=idx; out_last<=(idx==M-1).
//      - Go EMIT.
//    EMIT:
//      - out_valid=1; out_pre/out_idx/out_last held stable while out_ready=0.
//      - On out_valid & out_ready:
//          idx==M-1 -> IDLE, idx<=0;
//          else     -> idx<=idx+1, go FETCH.
//  Latency and throughput:
//    - x handshake at cycle t -> w_req at t+1 -> first out_valid at t+3.
//    - Min 3 cycles per neuron; a full layer takes >= 3*M cycles after the x handshake.
//  Handshake rules:
//    - in_ready=0 in every non-IDLE state; x_reg is never overwritten mid-layer.
//    - w_req is asserted only in FETCH: exactly one read per neuron, never during backpressure.
//    - Zero-cycle reaccept: x is not accepted in the same cycle the last result is taken
//      (IDLE is entered first).
//  Arithmetic:
//    - Full-precision signed, no saturation or rounding.
//    - Bias is sign-extended to ACC_WIDTH before the add; ACC_WIDTH guarantees no overflow.
//  abort (sampled each edge, priority over every other transition):
//    - Next state IDLE, out_valid drops next cycle, idx<=0.
//    - A w_rdata returning after abort is ignored.
//    - abort in IDLE has no effect, and an x offered in that same cycle is not accepted.
//  Reset mid-operation:
//    - Any state returns immediately to IDLE with reset values.
//    - No partial result is emitted after rst_n rises.
//  M==1: after EMIT handshake return straight to IDLE, out_last=1.
// STRUCTURE
//  npu_pkg:
//    - seq_state_t enum {IDLE, FETCH, CAPTURE, EMIT}.
//    - acc_width(N,DATA_WIDTH) function, shared with the PreActivation wrapper.
//  One sub-module: PreActivation instance u_pre; its ACC_WIDTH is passed explicitly.
//  Local logic: x_reg, idx counter, FSM, output registers.
// TESTING (N=4, DATA_WIDTH=8, M=3, ACC_WIDTH=18)
//  1. Basic layer. x={1,2,3,4}, out_ready=1:
//     - rows w0={1,1,1,1}, b0=0 -> 10, idx0;
//     - w1={-1,-1,-1,-1}, b1=5 -> -5, idx1;
//     - w2={0,0,0,2}, b2=-1 -> 7, idx2, out_last=1.
//     - First out_valid 3 cycles after the x handshake.
//  2. Extremes: x, w all -128, b=-128 -> out_pre=65408, no overflow.
//  3. Backpressure: out_ready low 5 cycles in EMIT:
//     - out_pre/out_idx stable, w_req stays 0, in_ready stays 0.
//     - Exactly 3 w_req pulses per layer.
//  4. Busy input: in_valid held with new x during a layer:
//     - not accepted until IDLE;
//     - second layer uses the new x, first layer's results unaffected.
//  5. abort during EMIT of idx1:
//     - out_valid low next cycle, in_ready=1, busy=0;
//     - next layer restarts at idx0.
//  6. Reset mid-FETCH:
//     - all outputs at reset values while rst_n is low;
//     - after release, a fresh layer produces correct results from idx0.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared types and width helpers for the layer sequencer and its
// pre-activation datapath.
package layer_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } seq_state_t;

  // Full-precision width of an N-term dot product plus a bias term.
  function automatic int acc_width(input int n, input int dataWidth);
    return 2 * dataWidth + $clog2(n);
  endfunction

endpackage

// File: rtl/layer_sequencer_preact.sv
// Combinational pre-activation: signed dot(x, w) plus sign-extended bias,
// computed at full precision.
module PreActivation
  import layer_sequencer_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width(N, DATA_WIDTH)
) (
  input  logic [N*DATA_WIDTH-1:0] x_i,
  input  logic [N*DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [ACC_WIDTH-1:0]    pre_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc;

  always_comb begin
    prod = '0;
    acc  = ACC_WIDTH'(signed'(b_i));
    for (int i = 0; i < N; i++) begin
      prod = signed'(x_i[i*DATA_WIDTH +: DATA_WIDTH]) * signed'(w_i[i*DATA_WIDTH +: DATA_WIDTH]);
      acc  = acc + ACC_WIDTH'(prod);
    end
  end

  assign pre_o = acc;

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: latch x, then fetch/compute/emit one
// neuron at a time through a shared PreActivation datapath.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int ACC_WIDTH  = acc_width(N, DATA_WIDTH),
  parameter int IDX_WIDTH  = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_x,
  output logic                    w_req,
  output logic [IDX_WIDTH-1:0]    w_addr,
  input  logic [N*DATA_WIDTH-1:0] w_rdata,
  input  logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_pre,
  output logic [IDX_WIDTH-1:0]    out_idx,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(M - 1);

  seq_state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]        idx_q, idx_d;
  logic [N*DATA_WIDTH-1:0]     x_q, x_d;
  logic [ACC_WIDTH-1:0]        pre_q;
  logic [IDX_WIDTH-1:0]        outIdx_q;
  logic                        outLast_q;
  logic                        capture;
  logic [ACC_WIDTH-1:0]        preW;

  PreActivation #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_pre (
    .x_i   (x_q),
    .w_i   (w_rdata),
    .b_i   (b_rdata),
    .pre_o (preW)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including an x offered while idle.
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      x_d     = x_q;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      pre_q     <= '0;
      outIdx_q  <= '0;
      outLast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      if (capture) begin
        pre_q     <= preW;
        outIdx_q  <= idx_q;
        outLast_q <= (idx_q == LAST_IDX);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign w_req     = (state_q == FETCH);
  assign w_addr    = idx_q;
  assign out_valid = (state_q == EMIT);
  assign out_pre   = pre_q;
  assign out_idx   = outIdx_q;
  assign out_last  = outLast_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer with N=4, DATA_WIDTH=8, M=3.
module tb_layer_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int M  = 3;
  localparam int AW = 18;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*DW-1:0] in_x = '0;
  logic          w_req;
  logic [IW-1:0] w_addr;
  logic [N*DW-1:0] w_rdata = '0;
  logic [DW-1:0] b_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_pre;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  typedef struct {
    int pre;
    int idx;
    int last;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  int wreqCount = 0;

  logic [N*DW-1:0] wrow[M];
  logic [DW-1:0]   brow[M];

  layer_sequencer #(
    .N(N), .DATA_WIDTH(DW), .M(M), .ACC_WIDTH(AW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .w_req(w_req), .w_addr(w_addr), .w_rdata(w_rdata), .b_rdata(b_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pre(out_pre),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency.
  always @(posedge clk) begin
    if (w_req) begin
      w_rdata <= wrow[w_addr];
      b_rdata <= brow[w_addr];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (w_req) wreqCount++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected result", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_pre", $signed(out_pre), e.pre);
        checkOutput("out_idx", int'(out_idx), e.idx);
        checkOutput("out_last", int'(out_last), e.last);
      end
    end
  end

  function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectLayer(input int p0, input int p1, input int p2);
    exp_t t;
    t.pre = p0; t.idx = 0; t.last = 0; sb.push_back(t);
    t.pre = p1; t.idx = 1; t.last = 0; sb.push_back(t);
    t.pre = p2; t.idx = 2; t.last = 1; sb.push_back(t);
  endtask

  task automatic loadBasic();
    wrow[0] = pack4(1, 1, 1, 1);     brow[0] = 8'd0;
    wrow[1] = pack4(-1, -1, -1, -1); brow[1] = 8'd5;
    wrow[2] = pack4(0, 0, 0, 2);     brow[2] = 8'hFF;
  endtask

  task automatic applyStimulus(input logic [N*DW-1:0] x);
    bit ok = 0;
    in_x = x;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) checkOutput("in_ready timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && sb.size() == 0) begin ok = 1; break; end
      tick();
    end
    if (!ok) checkOutput("layer completion timeout", sb.size(), 0);
  endtask

  task automatic waitValid();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) checkOutput("out_valid timeout", 0, 1);
  endtask

  initial begin
    int startReq;
    bit seen;
    logic [N*DW-1:0] x1;
    x1 = pack4(1, 2, 3, 4);
    loadBasic();

    // Reset values
    #12;
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset w_req", int'(w_req), 0);
    checkOutput("reset out_pre", int'(out_pre), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic layer with latency checks
    out_ready = 1'b1;
    expectLayer(10, -5, 7);
    in_x = x1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("t+1 w_req", int'(w_req), 1);
    checkOutput("t+1 w_addr", int'(w_addr), 0);
    checkOutput("t+1 out_valid", int'(out_valid), 0);
    checkOutput("t+1 in_ready", int'(in_ready), 0);
    tick();
    checkOutput("t+2 out_valid", int'(out_valid), 0);
    tick();
    checkOutput("t+3 out_valid", int'(out_valid), 1);
    waitDone();

    // Extremes
    for (int i = 0; i < M; i++) begin
      wrow[i] = pack4(-128, -128, -128, -128);
      brow[i] = 8'h80;
    end
    expectLayer(65408, 65408, 65408);
    applyStimulus(pack4(-128, -128, -128, -128));
    waitDone();
    loadBasic();

    // Backpressure on idx0
    out_ready = 1'b0;
    expectLayer(10, -5, 7);
    startReq = wreqCount;
    applyStimulus(x1);
    waitValid();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp out_pre", $signed(out_pre), 10);
      checkOutput("bp out_idx", int'(out_idx), 0);
      checkOutput("bp w_req", int'(w_req), 0);
      checkOutput("bp in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    waitDone();
    checkOutput("w_req pulses per layer", wreqCount - startReq, 3);

    // New x held during a layer
    expectLayer(10, -5, 7);
    expectLayer(3, 2, 1);
    applyStimulus(x1);
    in_x = pack4(2, 0, 0, 1);
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin seen = 1; break; end
      tick();
    end
    checkOutput("second x accepted", int'(seen), 1);
    checkOutput("first layer done before reaccept", sb.size(), 3);
    tick();
    in_valid = 1'b0;
    waitDone();

    // Abort during EMIT of idx1
    out_ready = 1'b0;
    begin
      exp_t t;
      t.pre = 10; t.idx = 0; t.last = 0;
      sb.push_back(t);
    end
    applyStimulus(x1);
    waitValid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tick();
    checkOutput("pre-abort out_valid", int'(out_valid), 1);
    checkOutput("pre-abort out_idx", int'(out_idx), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort out_valid", int'(out_valid), 0);
    checkOutput("abort in_ready", int'(in_ready), 1);
    checkOutput("abort busy", int'(busy), 0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_x = x1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort in IDLE blocks x", int'(busy), 0);
    out_ready = 1'b1;
    expectLayer(10, -5, 7);
    applyStimulus(x1);
    waitDone();

    // Reset mid-FETCH
    applyStimulus(x1);
    checkOutput("pre-reset w_req", int'(w_req), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst w_req", int'(w_req), 0);
    checkOutput("rst out_valid", int'(out_valid), 0);
    checkOutput("rst in_ready", int'(in_ready), 1);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst out_pre", int'(out_pre), 0);
    checkOutput("rst out_idx", int'(out_idx), 0);
    checkOutput("rst out_last", int'(out_last), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expectLayer(10, -5, 7);
    applyStimulus(x1);
    waitDone();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
